test_result_monitor: RTL and testbench
======================================

TEST_RESULT_MONITOR -- requirements
Module: test_result_monitor

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent success/next-test GPIO pairs monitored.
REQ-002 Parameter TESTS_PER_RUN, default 4, next-test rising edges per run; the last edge is the result edge.
REQ-003 Parameter TIMEOUT_CYCLES, default 500000, clk cycles allowed per run before timeout; 0 disables timeout.
REQ-004 Parameter STRICT_MODE, default 0; 1 = success sampled at every edge and any low sample fails the run.
REQ-005 clk  input  1  single block clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start_i  input  1  one-cycle pulse; arms all channels and clears results.
REQ-008 success_i  input  CHANNELS  asynchronous per-channel success level from pad.
REQ-009 next_test_i  input  CHANNELS  asynchronous per-channel test-strobe from pad.
REQ-010 done_o  output  CHANNELS  channel finished (pass, fail or timeout), sticky until start_i.
REQ-011 pass_o  output  CHANNELS  valid when done_o; 1 = passed.
REQ-012 timeout_o  output  CHANNELS  channel finished by timeout.
REQ-013 edge_count_o  output  CHANNELS*8  per-channel edges seen this run, channel 0 in LSBs.
REQ-014 all_done_o  output  1  AND of done_o.
REQ-015 all_pass_o  output  1  all_done_o AND all pass_o.

Function
REQ-016 Per-channel 2-flop synchroniser on success_i and next_test_i, plus one register stage for rising-edge detect.
REQ-017 Edge event asserts exactly 3 clk cycles after raw next_test_i rise; synced success sampled in that same cycle (equal path depth).
REQ-018 Per-channel FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT; encoding from package.
REQ-019 IDLE -> RUN on start_i; edges in IDLE ignored, count held at 0.
REQ-020 RUN: each edge increments edge_count (saturates at 255); edge count == TESTS_PER_RUN -> PASS if sampled success=1, else FAIL.
REQ-021 STRICT_MODE=1: any edge with sampled success=0 in RUN -> FAIL immediately.
REQ-022 Shared cycle counter clears on start_i, increments while any channel in RUN, saturates at TIMEOUT_CYCLES.
REQ-023 Counter reaching TIMEOUT_CYCLES moves every channel still in RUN to TIMEOUT; edge in same cycle wins (result edge yields PASS/FAIL).
REQ-024 PASS/FAIL/TIMEOUT hold; further edges ignored, counts frozen.
REQ-025 start_i in any state (incl. mid-run) -> RUN, counts cleared, outputs cleared next cycle; simultaneous edge discarded.
REQ-026 Outputs registered: done_o/pass_o/timeout_o update the cycle after FSM transition decision.
REQ-027 TESTS_PER_RUN must be 1..255; elaboration error otherwise.

Reset
REQ-028 rst_n low: all FSMs IDLE, synchronisers 0, counters 0, all outputs 0 (all_done_o=0, all_pass_o=0).
REQ-029 Reset release needs no start_i-free cycles; first start_i accepted on first clock with rst_n high.

Structure
REQ-030 Package test_result_pkg holds FSM state enum, EDGE_CNT_W=8, default parameter constants.
REQ-031 Sub-module tr_sync_edge: 2-flop sync of strobe and level, rising-edge pulse output, level aligned to pulse; one instance per channel.
REQ-032 Timeout counter width = clog2(TIMEOUT_CYCLES+1), min 1.

Verification
REQ-033 CH=2, TPR=4: start, 4 next_test pulses each with success=1 on 4th -> done_o=2'b11, pass_o=2'b11, all_pass_o=1, edge_count 4/4.
REQ-034 Channel 1 success=0 at 4th edge, STRICT_MODE=0 -> pass_o=2'b01, done_o=2'b11, all_pass_o=0.
REQ-035 STRICT_MODE=1, success=0 at edge 2 ch0 -> ch0 FAIL 1 cycle after edge event, edge_count=2, edges 3-4 ignored.
REQ-036 TIMEOUT_CYCLES=100, ch1 only 2 edges -> cycle 100 ch1 timeout_o=1, pass_o[1]=0, edge_count=2; ch0 unaffected.
REQ-037 start_i mid-run after 2 edges -> counts 0, done_o=0; 4 new edges -> PASS.
REQ-038 rst_n asserted mid-run asynchronously -> all outputs 0 within same cycle, FSMs IDLE; edges before start_i ignored.

Source files
------------

// File: rtl/test_result_pkg.sv
// -----------------------------------------------------------------------------
// test_result_pkg
// Shared types and constants for the test result monitor.
//   tr_state_e        per-channel FSM state encoding
//   EDGE_CNT_W        width of each per-channel edge counter
//   DEF_*             default values for the monitor parameters
//   timeout_cnt_w()   width of the shared run-timeout counter
// -----------------------------------------------------------------------------
package test_result_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } tr_state_e;

  localparam int EDGE_CNT_W = 8;

  localparam int DEF_CHANNELS       = 2;
  localparam int DEF_TESTS_PER_RUN  = 4;
  localparam int DEF_TIMEOUT_CYCLES = 500000;
  localparam int DEF_STRICT_MODE    = 0;

  // Enough bits to hold the value TIMEOUT_CYCLES itself; never narrower
  // than one bit so a disabled timeout still elaborates cleanly.
  function automatic int timeout_cnt_w(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/tr_sync_edge.sv
// -----------------------------------------------------------------------------
// tr_sync_edge
// Brings one asynchronous strobe and one asynchronous level into the clk
// domain. The strobe goes through a 2-flop synchroniser and a registered
// rising-edge detector; the level goes through the same number of flops so
// that level_aligned shows the level as it was when the strobe rose.
//   clk           block clock
//   rst_n         asynchronous active-low reset
//   strobe        raw strobe from pad
//   level         raw level from pad
//   edge_pulse    one-cycle pulse, 3 clk cycles after strobe rises
//   level_aligned synchronised level, same path depth as edge_pulse
// -----------------------------------------------------------------------------
module tr_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  input  logic level,
  output logic edge_pulse,
  output logic level_aligned
);

  logic strobe_meta_reg;
  logic strobe_sync_reg;
  logic strobe_prev_reg;
  logic edge_reg;
  logic level_meta_reg;
  logic level_sync_reg;
  logic level_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe_meta_reg <= 1'b0;
      strobe_sync_reg <= 1'b0;
      strobe_prev_reg <= 1'b0;
      edge_reg        <= 1'b0;
      level_meta_reg  <= 1'b0;
      level_sync_reg  <= 1'b0;
      level_reg       <= 1'b0;
    end else begin
      strobe_meta_reg <= strobe;
      strobe_sync_reg <= strobe_meta_reg;
      strobe_prev_reg <= strobe_sync_reg;
      // Registered detect: third flop on the strobe path.
      edge_reg        <= strobe_sync_reg & ~strobe_prev_reg;
      level_meta_reg  <= level;
      level_sync_reg  <= level_meta_reg;
      // Third flop on the level path keeps it aligned with edge_reg.
      level_reg       <= level_sync_reg;
    end
  end

  assign edge_pulse    = edge_reg;
  assign level_aligned = level_reg;

endmodule

// File: rtl/test_result_monitor.sv
// -----------------------------------------------------------------------------
// test_result_monitor
// Watches CHANNELS independent success / next-test GPIO pairs. start_i arms
// every channel; each channel then counts rising edges of next_test_i and
// judges the run on the TESTS_PER_RUN-th edge from the success level sampled
// with it. A shared cycle counter times out channels that never finish.
//   clk           block clock
//   rst_n         asynchronous active-low reset
//   start_i       one-cycle pulse, (re)arms all channels and clears results
//   success_i     per-channel asynchronous success level
//   next_test_i   per-channel asynchronous test strobe
//   done_o        per-channel finished flag (sticky until start_i)
//   pass_o        per-channel pass flag, valid with done_o
//   timeout_o     per-channel finished-by-timeout flag
//   edge_count_o  per-channel edge counts, 8 bits each, channel 0 in LSBs
//   all_done_o    every channel done
//   all_pass_o    every channel done and passed
// -----------------------------------------------------------------------------
module test_result_monitor
  import test_result_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int TESTS_PER_RUN  = DEF_TESTS_PER_RUN,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int STRICT_MODE    = DEF_STRICT_MODE
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start_i,
  input  logic [CHANNELS-1:0]            success_i,
  input  logic [CHANNELS-1:0]            next_test_i,
  output logic [CHANNELS-1:0]            done_o,
  output logic [CHANNELS-1:0]            pass_o,
  output logic [CHANNELS-1:0]            timeout_o,
  output logic [CHANNELS*EDGE_CNT_W-1:0] edge_count_o,
  output logic                           all_done_o,
  output logic                           all_pass_o
);

  localparam int                    TO_W     = timeout_cnt_w(TIMEOUT_CYCLES);
  localparam logic [TO_W-1:0]       TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [EDGE_CNT_W-1:0] TPR_CNT  = EDGE_CNT_W'(TESTS_PER_RUN);
  localparam logic [EDGE_CNT_W-1:0] CNT_MAX  = '1;

  if (TESTS_PER_RUN < 1 || TESTS_PER_RUN > 255) begin : g_bad_tests_per_run
    $error("test_result_monitor: TESTS_PER_RUN must be within 1..255");
  end

  // ---------------------------------------------------------------------------
  // Shared run-timeout counter
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] run_vec;
  logic [TO_W-1:0]     cycle_cnt_reg;
  logic                any_run;
  logic                timeout_hit;

  assign any_run = |run_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_reg <= '0;
    end else if (start_i) begin
      cycle_cnt_reg <= '0;
    end else if (any_run && (cycle_cnt_reg != TO_LIMIT)) begin
      cycle_cnt_reg <= cycle_cnt_reg + TO_W'(1);
    end
  end

  // A zero limit means the counter never arms a timeout.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_cnt_reg == TO_LIMIT);

  // ---------------------------------------------------------------------------
  // Per-channel synchroniser and result FSM
  // ---------------------------------------------------------------------------
  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic                  edge_evt;
    logic                  succ_smp;
    tr_state_e             state_reg;
    tr_state_e             state_next;
    logic [EDGE_CNT_W-1:0] cnt_reg;
    logic [EDGE_CNT_W-1:0] cnt_next;
    logic [EDGE_CNT_W-1:0] cnt_inc;
    logic                  done_reg;
    logic                  pass_reg;
    logic                  timeout_reg;
    logic                  done_next;
    logic                  pass_next;
    logic                  timeout_next;

    tr_sync_edge u_sync (
      .clk           (clk),
      .rst_n         (rst_n),
      .strobe        (next_test_i[gi]),
      .level         (success_i[gi]),
      .edge_pulse    (edge_evt),
      .level_aligned (succ_smp)
    );

    // State, count and registered result flags.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_reg   <= ST_IDLE;
        cnt_reg     <= '0;
        done_reg    <= 1'b0;
        pass_reg    <= 1'b0;
        timeout_reg <= 1'b0;
      end else begin
        state_reg   <= state_next;
        cnt_reg     <= cnt_next;
        done_reg    <= done_next;
        pass_reg    <= pass_next;
        timeout_reg <= timeout_next;
      end
    end

    assign cnt_inc = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + EDGE_CNT_W'(1);

    // Next-state decision. start_i overrides everything, including an edge
    // arriving in the same cycle. In RUN an edge takes priority over the
    // timeout so the result edge is still judged.
    always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      if (start_i) begin
        state_next = ST_RUN;
        cnt_next   = '0;
      end else begin
        case (state_reg)
          ST_RUN: begin
            if (edge_evt) begin
              cnt_next = cnt_inc;
              if ((STRICT_MODE != 0) && !succ_smp) begin
                state_next = ST_FAIL;
              end else if (cnt_inc == TPR_CNT) begin
                state_next = succ_smp ? ST_PASS : ST_FAIL;
              end
            end else if (timeout_hit) begin
              state_next = ST_TIMEOUT;
            end
          end
          default: begin
            // IDLE waits for start_i; PASS/FAIL/TIMEOUT hold with counts frozen.
            state_next = state_reg;
          end
        endcase
      end
    end

    // Result flags decoded from the next state so they register together
    // with the state change.
    always_comb begin
      done_next    = 1'b0;
      pass_next    = 1'b0;
      timeout_next = 1'b0;
      case (state_next)
        ST_PASS: begin
          done_next = 1'b1;
          pass_next = 1'b1;
        end
        ST_FAIL: begin
          done_next = 1'b1;
        end
        ST_TIMEOUT: begin
          done_next    = 1'b1;
          timeout_next = 1'b1;
        end
        default: begin
          done_next = 1'b0;
        end
      endcase
    end

    assign run_vec[gi]                                 = (state_reg == ST_RUN);
    assign done_o[gi]                                  = done_reg;
    assign pass_o[gi]                                  = pass_reg;
    assign timeout_o[gi]                               = timeout_reg;
    assign edge_count_o[gi*EDGE_CNT_W +: EDGE_CNT_W]   = cnt_reg;
  end

  assign all_done_o = &done_o;
  assign all_pass_o = all_done_o & (&pass_o);

endmodule

// File: tb/tb_test_result_monitor.sv
// -----------------------------------------------------------------------------
// tb_test_result_monitor
// Three monitors share one stimulus: a default build, a strict build with the
// timeout disabled, and a build with a 100-cycle timeout. Expected results per
// build are pushed to a scoreboard queue when a run is driven and compared once
// the run has settled.
// -----------------------------------------------------------------------------
module tb_test_result_monitor;

  localparam int CH  = 2;
  localparam int TPR = 4;
  localparam int NI  = 3;

  logic          clk;
  logic          rst_n;
  logic          start_i;
  logic [CH-1:0] success_i;
  logic [CH-1:0] next_test_i;

  logic [CH-1:0]   done_w     [NI];
  logic [CH-1:0]   pass_w     [NI];
  logic [CH-1:0]   tmo_w      [NI];
  logic [CH*8-1:0] cnt_w      [NI];
  logic            all_done_w [NI];
  logic            all_pass_w [NI];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int start_cyc = 0;

  typedef struct {
    string         tag;
    int            inst;
    logic [CH-1:0] done;
    logic [CH-1:0] pass;
    logic [CH-1:0] tmo;
    logic [15:0]   cnt;
  } exp_t;

  exp_t sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  test_result_monitor #(.CHANNELS(CH), .TESTS_PER_RUN(TPR), .TIMEOUT_CYCLES(500000), .STRICT_MODE(0)) u_dut_base (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .success_i(success_i), .next_test_i(next_test_i),
    .done_o(done_w[0]), .pass_o(pass_w[0]), .timeout_o(tmo_w[0]), .edge_count_o(cnt_w[0]),
    .all_done_o(all_done_w[0]), .all_pass_o(all_pass_w[0])
  );

  test_result_monitor #(.CHANNELS(CH), .TESTS_PER_RUN(TPR), .TIMEOUT_CYCLES(0), .STRICT_MODE(1)) u_dut_strict (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .success_i(success_i), .next_test_i(next_test_i),
    .done_o(done_w[1]), .pass_o(pass_w[1]), .timeout_o(tmo_w[1]), .edge_count_o(cnt_w[1]),
    .all_done_o(all_done_w[1]), .all_pass_o(all_pass_w[1])
  );

  test_result_monitor #(.CHANNELS(CH), .TESTS_PER_RUN(TPR), .TIMEOUT_CYCLES(100), .STRICT_MODE(0)) u_dut_to (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .success_i(success_i), .next_test_i(next_test_i),
    .done_o(done_w[2]), .pass_o(pass_w[2]), .timeout_o(tmo_w[2]), .edge_count_o(cnt_w[2]),
    .all_done_o(all_done_w[2]), .all_pass_o(all_pass_w[2])
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expected outcome of one channel given its edge count, the success level
  // at each edge (bit k = edge k), strictness and whether the run timed out.
  function automatic void model_ch(input int n, input logic [7:0] pat, input bit strict,
                                   input bit tmo_en, output logic done, output logic pass,
                                   output logic tmo, output logic [7:0] cnt);
    bit fin;
    fin  = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    tmo  = 1'b0;
    cnt  = 8'd0;
    for (int k = 0; k < n; k++) begin
      if (!fin) begin
        cnt = cnt + 8'd1;
        if (strict && !pat[k]) begin
          done = 1'b1;
          fin  = 1'b1;
        end else if (cnt == TPR) begin
          done = 1'b1;
          pass = pat[k];
          fin  = 1'b1;
        end
      end
    end
    if (!fin && tmo_en) begin
      done = 1'b1;
      tmo  = 1'b1;
    end
  endfunction

  task automatic push_expect(input string tag, input int n0, input logic [7:0] p0,
                             input int n1, input logic [7:0] p1, input bit long_wait);
    exp_t       e;
    logic       d, p, t;
    logic [7:0] c;
    for (int i = 0; i < NI; i++) begin
      e.tag  = tag;
      e.inst = i;
      model_ch(n0, p0, (i == 1), (i == 2) && long_wait, d, p, t, c);
      e.done[0] = d; e.pass[0] = p; e.tmo[0] = t; e.cnt[7:0] = c;
      model_ch(n1, p1, (i == 1), (i == 2) && long_wait, d, p, t, c);
      e.done[1] = d; e.pass[1] = p; e.tmo[1] = t; e.cnt[15:8] = c;
      sb_q.push_back(e);
    end
  endtask

  task automatic compare_all();
    exp_t e;
    logic ad;
    while (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      ad = &e.done;
      check_eq($sformatf("%s.i%0d.done", e.tag, e.inst), 32'(done_w[e.inst]), 32'(e.done));
      check_eq($sformatf("%s.i%0d.pass", e.tag, e.inst), 32'(pass_w[e.inst]), 32'(e.pass));
      check_eq($sformatf("%s.i%0d.tmo", e.tag, e.inst), 32'(tmo_w[e.inst]), 32'(e.tmo));
      check_eq($sformatf("%s.i%0d.cnt", e.tag, e.inst), 32'(cnt_w[e.inst]), 32'(e.cnt));
      check_eq($sformatf("%s.i%0d.all_done", e.tag, e.inst), 32'(all_done_w[e.inst]), 32'(ad));
      check_eq($sformatf("%s.i%0d.all_pass", e.tag, e.inst), 32'(all_pass_w[e.inst]),
               32'(ad & (&e.pass)));
      $display("run %s inst %0d: done=%b pass=%b tmo=%b cnt=%h", e.tag, e.inst,
               done_w[e.inst], pass_w[e.inst], tmo_w[e.inst], cnt_w[e.inst]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i   = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start_i   = 1'b0;
  endtask

  // Each edge: strobe high 3 cycles, low 5; success set with the rising strobe.
  task automatic drive_edges(input int n0, input logic [7:0] p0, input int n1, input logic [7:0] p1);
    int nmax;
    nmax = (n0 > n1) ? n0 : n1;
    for (int k = 0; k < nmax; k++) begin
      @(negedge clk);
      if (k < n0) begin
        success_i[0]   = p0[k];
        next_test_i[0] = 1'b1;
      end
      if (k < n1) begin
        success_i[1]   = p1[k];
        next_test_i[1] = 1'b1;
      end
      repeat (3) @(negedge clk);
      next_test_i = '0;
      repeat (5) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    success_i   = '0;
    next_test_i = '0;
    repeat (3) @(negedge clk);

    // Reset state of every build.
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("rst.i%0d.done", i), 32'(done_w[i]), 32'd0);
      check_eq($sformatf("rst.i%0d.cnt", i), 32'(cnt_w[i]), 32'd0);
      check_eq($sformatf("rst.i%0d.all", i), 32'({all_done_w[i], all_pass_w[i]}), 32'd0);
    end

    // Start accepted on the first clock after reset release; first edge
    // latency measured on channel 0.
    rst_n     = 1'b1;
    start_i   = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start_i = 1'b0;
    push_expect("all_pass", 4, 8'h0F, 4, 8'h0F, 1'b0);
    @(negedge clk);
    success_i[0]   = 1'b1;
    next_test_i[0] = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("lat_before", 32'(cnt_w[0][7:0]), 32'd0);
    @(negedge clk);
    check_eq("lat_after", 32'(cnt_w[0][7:0]), 32'd1);
    next_test_i[0] = 1'b0;
    repeat (4) @(negedge clk);
    drive_edges(3, 8'h07, 4, 8'h0F);
    compare_all();

    // Channel 1 low at the result edge.
    pulse_start();
    push_expect("ch1_fail", 4, 8'h0F, 4, 8'h07, 1'b0);
    drive_edges(4, 8'h0F, 4, 8'h07);
    compare_all();

    // Channel 0 low at edge 2 only: strict build fails early at count 2.
    pulse_start();
    push_expect("strict_e2", 4, 8'h0D, 4, 8'h0F, 1'b0);
    drive_edges(4, 8'h0D, 4, 8'h0F);
    compare_all();

    // Extra edges after the result edge are ignored.
    pulse_start();
    push_expect("extra_edges", 6, 8'h3F, 4, 8'h0F, 1'b0);
    drive_edges(6, 8'h3F, 4, 8'h0F);
    compare_all();

    // Channel 1 stalls after 2 edges: only the 100-cycle build times out.
    pulse_start();
    push_expect("timeout", 4, 8'h0F, 2, 8'h03, 1'b1);
    drive_edges(4, 8'h0F, 2, 8'h03);
    check_eq("timeout.early", 32'(tmo_w[2]), 32'd0);
    got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (tmo_w[2][1]) got = 1'b1;
    end
    if (!got) begin
      check_eq("timeout.wait", 32'd0, 32'd1);
    end else begin
      check_eq("timeout.latency", 32'(cyc - start_cyc), 32'd101);
    end
    repeat (3) @(negedge clk);
    compare_all();

    // Restart mid-run after 2 edges, then a full passing run.
    pulse_start();
    push_expect("mid_run", 2, 8'h03, 2, 8'h03, 1'b0);
    drive_edges(2, 8'h03, 2, 8'h03);
    compare_all();
    pulse_start();
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("restart.i%0d.cnt", i), 32'(cnt_w[i]), 32'd0);
      check_eq($sformatf("restart.i%0d.done", i), 32'(done_w[i]), 32'd0);
    end
    push_expect("after_restart", 4, 8'h0F, 4, 8'h0F, 1'b0);
    drive_edges(4, 8'h0F, 4, 8'h0F);
    compare_all();

    // Asynchronous reset mid-run, then edges without start are ignored.
    pulse_start();
    drive_edges(2, 8'h03, 2, 8'h03);
    check_eq("pre_rst.cnt", 32'(cnt_w[0]), 32'h0202);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("async_rst.i%0d.cnt", i), 32'(cnt_w[i]), 32'd0);
      check_eq($sformatf("async_rst.i%0d.done", i), 32'(done_w[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive_edges(2, 8'h03, 2, 8'h03);
    for (int i = 0; i < NI; i++) begin
      check_eq($sformatf("idle_edges.i%0d.cnt", i), 32'(cnt_w[i]), 32'd0);
      check_eq($sformatf("idle_edges.i%0d.done", i), 32'(done_w[i]), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
